// File: rtl/i2c_master_od.sv
// rtl/i2c_master_od.sv - open-drain I2C byte master with optional clock stretching (I2C_STRETCH_EN)
module i2c_master_od #(
    parameter int DIV   = 500,
    parameter int CNT_W = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    output logic       ready,
    input  logic [3:0] cmd,
    input  logic       nack,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       done,
    output logic       ack_err,
    output logic       busy,
    input  logic       scl_i,
    output logic       scl_oe,
    input  logic       sda_i,
    output logic       sda_oe
);
    typedef enum logic [2:0] {IDLE, START, WRITE, RACK, READ, SACK, STOP} state_t;

    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] P_HALF = CNT_W'(DIV / 2);
    localparam logic [CNT_W-1:0] P_Q1M  = CNT_W'(DIV / 4 - 1);
    localparam logic [CNT_W-1:0] P_Q3M  = CNT_W'(3 * DIV / 4 - 1);
    localparam logic [CNT_W-1:0] P_Q3   = CNT_W'(3 * DIV / 4);

    state_t           state, state_nx;
    logic [CNT_W-1:0] p;
    logic [2:0]       bit_idx;
    logic [3:1]       cmd_q;
    logic [7:0]       din_q;
    logic             nack_q;
    logic             sda_q;
    logic             scl_hold;
    logic             busy_q;
    logic             zero_done;
    logic [7:0]       rx_sh;
    logic [7:0]       dout_q;
    logic             hold;
    logic             accept;
    logic             phase_end;
    logic             last;
    logic             rd_done;

    // Phase that follows START (also the first phase when no START is requested).
    function automatic state_t after_start(input logic [3:1] c);
        if (c[1])      return WRITE;
        else if (c[2]) return READ;
        else if (c[3]) return STOP;
        else           return IDLE;
    endfunction

`ifdef I2C_STRETCH_EN
    // Freeze the phase counter while a slave keeps the released SCL low.
    assign hold = (state != IDLE) && (p >= P_HALF) && !scl_i;
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign hold       = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state decode and bus/handshake outputs.
    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        ready     = 1'b0;
        scl_oe    = 1'b0;
        sda_oe    = 1'b0;
        phase_end = (state != IDLE) && !hold && (p == P_LAST);
        case (state)
            IDLE: begin
                ready  = 1'b1;
                accept = req;
                scl_oe = scl_hold & busy_q;
                sda_oe = sda_q & busy_q;
                if (req) state_nx = cmd[0] ? START : after_start(cmd[3:1]);
            end
            START:       if (phase_end) state_nx = after_start(cmd_q);
            WRITE:       if (phase_end && bit_idx == 3'd7) state_nx = RACK;
            READ:        if (phase_end && bit_idx == 3'd7) state_nx = SACK;
            RACK, SACK:  if (phase_end) state_nx = cmd_q[3] ? STOP : IDLE;
            STOP:        if (phase_end) state_nx = IDLE;
            default:     state_nx = IDLE;
        endcase
        if (state != IDLE) begin
            scl_oe = (p < P_HALF);
            sda_oe = sda_q;
        end
        last    = phase_end && (state_nx == IDLE);
        rd_done = last && cmd_q[2] && !cmd_q[1];
        done    = zero_done | last;
        busy    = busy_q && !((state == STOP) && phase_end);
        dout    = rd_done ? rx_sh : dout_q;
    end

    // Phase counter, bit index, SDA drive and sampled data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p         <= '0;
            bit_idx   <= 3'd0;
            cmd_q     <= 3'd0;
            din_q     <= 8'h00;
            nack_q    <= 1'b0;
            sda_q     <= 1'b0;
            scl_hold  <= 1'b0;
            busy_q    <= 1'b0;
            zero_done <= 1'b0;
            rx_sh     <= 8'h00;
            dout_q    <= 8'h00;
            ack_err   <= 1'b1;
        end else begin
            zero_done <= 1'b0;
            if (accept) begin
                cmd_q     <= cmd[3:1];
                din_q     <= din;
                nack_q    <= nack;
                p         <= '0;
                bit_idx   <= 3'd0;
                zero_done <= (cmd == 4'd0);
                if (cmd[0]) busy_q <= 1'b1;
            end else if (state != IDLE && !hold) begin
                p <= (p == P_LAST) ? '0 : p + 1'b1;
                if (p == P_Q1M) begin
                    case (state)
                        START:       sda_q <= 1'b0;
                        WRITE:       sda_q <= ~din_q[3'd7 - bit_idx];
                        RACK, READ:  sda_q <= 1'b0;
                        SACK:        sda_q <= ~nack_q;
                        STOP:        sda_q <= 1'b1;
                        default:     sda_q <= sda_q;
                    endcase
                end
                if (p == P_Q3M) begin
                    if (state == START) sda_q <= 1'b1;
                    if (state == STOP)  sda_q <= 1'b0;
                end
                if (p == P_Q3) begin
                    if (state == RACK) ack_err <= sda_i;
                    if (state == READ) rx_sh   <= {rx_sh[6:0], sda_i};
                end
                if (p == P_LAST) begin
                    bit_idx <= (state_nx == state) ? bit_idx + 3'd1 : 3'd0;
                    if (state_nx == IDLE)  scl_hold <= (state != STOP);
                    if (state == STOP)     busy_q   <= 1'b0;
                    if (rd_done)           dout_q   <= rx_sh;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_master_od.sv
// tb/tb_i2c_master_od.sv - directed self-checking bench for i2c_master_od (DIV = 8)
module tb_i2c_master_od;
`ifdef I2C_STRETCH_EN
    localparam int S = 20;
`else
    localparam int S = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic [3:0] cmd = 4'd0;
    logic       nack = 1'b0;
    logic [7:0] din = 8'h00;
    logic       ready, done, ack_err, busy, scl_oe, sda_oe, scl_i, sda_i;
    logic [7:0] dout;
    logic       slave_scl_low = 1'b0;
    logic       slave_sda_low = 1'b0;

    int checks = 0;
    int failures = 0;
    int k = 0;
    logic [7:0] obs_byte;
    logic       scl_rel;

    assign scl_i = !(scl_oe || slave_scl_low);
    assign sda_i = !(sda_oe || slave_sda_low);

    i2c_master_od #(.DIV(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ready(ready), .cmd(cmd),
        .nack(nack), .din(din), .dout(dout), .done(done), .ack_err(ack_err),
        .busy(busy), .scl_i(scl_i), .scl_oe(scl_oe), .sda_i(sda_i), .sda_oe(sda_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic goto(input int target);
        while (k < target) tick(1);
    endtask

    // Accept a command; afterwards k = 1 is the first cycle of the first phase.
    task automatic issue(input logic [3:0] c, input logic [7:0] d, input logic n);
        req  = 1'b1;
        cmd  = c;
        din  = d;
        nack = n;
        @(posedge clk);
        #1;
        req = 1'b0;
        k   = 1;
    endtask

    // SDA line value at each SCL rise of the eight data phases starting at phase 1.
    task automatic grab_byte(output logic [7:0] b, output logic rel);
        b   = 8'h00;
        rel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            goto(8 * (1 + i) + 5);
            b[7 - i] = sda_i;
            rel      = rel & !scl_oe;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(2);
        chk("rst_ready", ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_lines", {scl_oe, sda_oe}, 2'b00);
        chk("rst_dout", dout, 8'h00);
        chk("rst_ack_err", ack_err, 1'b1);
        rst_n = 1'b1;
        tick(2);

        // START|WRITE|STOP 0xA5 with slave ACK
        issue(4'b1011, 8'hA5, 1'b0);
        chk("t1_busy_rise", busy, 1'b1);
        chk("t1_ready_low", ready, 1'b0);
        chk("t1_scl_low_p0", scl_oe, 1'b1);
        goto(10);
        req = 1'b1;
        cmd = 4'b0000;
        tick(1);
        req = 1'b0;
        chk("t1_req_ignored", done, 1'b0);
        grab_byte(obs_byte, scl_rel);
        chk("t1_sda_bits", obs_byte, 8'hA5);
        chk("t1_scl_released", scl_rel, 1'b1);
        goto(73);
        slave_sda_low = 1'b1;
        goto(81);
        slave_sda_low = 1'b0;
        goto(87);
        chk("t1_done_early", done, 1'b0);
        tick(1);
        chk("t1_done_88", done, 1'b1);
        chk("t1_ack_err", ack_err, 1'b0);
        chk("t1_busy_fall", busy, 1'b0);
        tick(1);
        chk("t1_ready", ready, 1'b1);
        chk("t1_lines_free", {scl_oe, sda_oe}, 2'b00);

        // START|WRITE back-to-back, slave NACK, bus held
        issue(4'b0011, 8'h5A, 1'b0);
        goto(80);
        chk("t2_done", done, 1'b1);
        chk("t2_ack_err", ack_err, 1'b1);
        tick(1);
        chk("t2_scl_hold", scl_oe, 1'b1);
        chk("t2_sda_rel", sda_oe, 1'b0);
        chk("t2_busy", busy, 1'b1);

        // Repeated START then READ|STOP with NACK, slave sends 0x3C
        issue(4'b0001, 8'h00, 1'b0);
        goto(5);
        chk("t3_rs_scl_rel", scl_oe, 1'b0);
        goto(7);
        chk("t3_rs_sda_low", sda_oe, 1'b1);
        tick(1);
        chk("t3_rs_done", done, 1'b1);
        tick(1);
        chk("t3_rs_hold", {scl_oe, sda_oe}, 2'b11);
        issue(4'b1100, 8'h00, 1'b1);
        obs_byte = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            slave_sda_low = !obs_byte[7 - i];
            tick(8);
        end
        slave_sda_low = 1'b0;
        goto(71);
        chk("t3_sack_rel", sda_oe, 1'b0);
        goto(80);
        chk("t3_done", done, 1'b1);
        chk("t3_dout", dout, 8'h3C);
        tick(1);
        chk("t3_dout_kept", dout, 8'h3C);
        chk("t3_lines_free", {scl_oe, sda_oe}, 2'b00);
        chk("t3_busy", busy, 1'b0);

        // Slave stretches SCL 20 cycles in bit 3
        issue(4'b1011, 8'hA5, 1'b0);
        goto(37);
        slave_scl_low = 1'b1;
        tick(20);
        slave_scl_low = 1'b0;
        goto(73 + S);
        slave_sda_low = 1'b1;
        goto(81 + S);
        slave_sda_low = 1'b0;
        goto(87 + S);
        chk("t4_done_early", done, 1'b0);
        tick(1);
        chk("t4_done_delay", done, 1'b1);
        chk("t4_ack_err", ack_err, 1'b0);
        tick(1);

        // Reset mid-WRITE at bit 4
        issue(4'b1011, 8'h00, 1'b0);
        goto(42);
        chk("t5_pre_lines", {scl_oe, sda_oe}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("t5_lines_rel", {scl_oe, sda_oe}, 2'b00);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("t5_ready", ready, 1'b1);
        chk("t5_ack_err", ack_err, 1'b1);
        chk("t5_busy", busy, 1'b0);

        // cmd = 0: done next cycle, no line activity
        issue(4'b0000, 8'hFF, 1'b0);
        chk("t6_zero_done", done, 1'b1);
        chk("t6_zero_lines", {scl_oe, sda_oe, busy}, 3'b000);
        tick(1);
        chk("t6_zero_pulse", done, 1'b0);

        // WRITE and READ both set: write only
        issue(4'b1111, 8'hC3, 1'b0);
        grab_byte(obs_byte, scl_rel);
        chk("t6_wr_bits", obs_byte, 8'hC3);
        goto(87);
        chk("t6_wr_done_early", done, 1'b0);
        tick(1);
        chk("t6_wr_done", done, 1'b1);
        chk("t6_wr_ack_err", ack_err, 1'b1);
        chk("t6_wr_dout", dout, 8'h00);
        chk("t6_wr_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
